// File: rtl/read_ecc_pkg.sv
// read_ecc_pkg: shared encodings and helpers for the read-path ECC checker.
package read_ecc_pkg;

    localparam int ECC_BYTES = 3;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        CORRECTED = 2'd1,
        ECC_ERR   = 2'd2,
        UNCORR    = 2'd3
    } ecc_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_SYND,
        S_CLASS,
        S_EMIT,
        S_DONE
    } state_e;

    // Row pairs occupy E[2K-1:0]; column pairs always sit at E[21:16].
    function automatic logic [23:0] ecc_used_mask(input int k);
        logic [23:0] m;
        m = 24'h3F0000;
        for (int i = 0; i < 2 * k; i++) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ecc_syndrome_classify.sv
// ecc_syndrome_classify: maps a raw ECC syndrome to status and correction address.
module ecc_syndrome_classify
    import read_ecc_pkg::*;
#(
    parameter int K = 7
) (
    input  logic [23:0]  syn,
    output ecc_status_e  status,
    output logic [K-1:0] offset,
    output logic [2:0]   bit_idx
);

    logic [23:0]  s;
    logic         pairs_ok;
    logic [K-1:0] row_odd;

    always_comb begin
        s = syn & ecc_used_mask(K);
        pairs_ok = 1'b1;
        row_odd = '0;
        for (int i = 0; i < K; i++) begin
            pairs_ok &= s[2*i] ^ s[2*i+1];
            row_odd[i] = s[2*i+1];
        end
        for (int j = 0; j < 3; j++) pairs_ok &= s[16+2*j] ^ s[17+2*j];
        status = (s == '0) ? CLEAN :
                 pairs_ok ? CORRECTED :
                 ($countones(s) == 1) ? ECC_ERR : UNCORR;
        offset = (status == CORRECTED) ? row_odd : '0;
        bit_idx = (status == CORRECTED) ? {s[21], s[19], s[17]} : 3'd0;
    end

endmodule

// File: rtl/read_ecc_checker.sv
// read_ecc_checker: per-chunk compare of computed vs stored ECC after a page read,
// reporting each chunk's classification on a backpressured result channel.
module read_ecc_checker
    import read_ecc_pkg::*;
#(
    parameter int  CHUNK_LOG2  = 7,
    parameter int  NUM_CHUNKS  = 64,
    parameter int  RAM_AW      = 10,
    parameter int  CALC_BASE   = 1,
    parameter int  STORED_BASE = 513,
    parameter int  RAM_RD_LAT  = 1,
    localparam int CW          = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     ram_en,
    output logic [RAM_AW-1:0]        ram_addr,
    input  logic [7:0]               ram_dout,
    output logic                     busy,
    output logic                     done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [1:0]               res_status,
    output logic [CW-1:0]            res_chunk,
    output logic [CW+CHUNK_LOG2-1:0] res_byte,
    output logic [2:0]               res_bit,
    output logic [CW:0]              cnt_corr,
    output logic [CW:0]              cnt_eccerr,
    output logic [CW:0]              cnt_uncorr
);

    localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

    state_e                           state;
    logic [CW-1:0]                    chunk;
    logic [2:0]                       fcnt;
    logic [23:0]                      calc, stored, syn_q;
    logic [RAM_RD_LAT-1:0]            tv;
    logic [RAM_RD_LAT-1:0][2:0]       ti;
    logic                             cap_v;
    logic [2:0]                       cap_i;
    ecc_status_e                      cls_status;
    logic [CHUNK_LOG2-1:0]            cls_off;
    logic [2:0]                       cls_bit;

    // Byte index 0..2 selects the computed code, 3..5 the stored code.
    function automatic logic [RAM_AW-1:0] addr_of(input logic [CW-1:0] c, input logic [2:0] idx);
        int a;
        a = (idx < 3'd3) ? CALC_BASE + ECC_BYTES * int'(c) + int'(idx)
                         : STORED_BASE + ECC_BYTES * int'(c) + int'(idx) - ECC_BYTES;
        return a[RAM_AW-1:0];
    endfunction

    ecc_syndrome_classify #(.K(CHUNK_LOG2)) u_cls (
        .syn     (syn_q),
        .status  (cls_status),
        .offset  (cls_off),
        .bit_idx (cls_bit)
    );

    assign cap_v = tv[RAM_RD_LAT-1];
    assign cap_i = ti[RAM_RD_LAT-1];

    // Tag pipe mirrors RAM latency so each returning byte knows its slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tv <= '0;
            ti <= '0;
        end else begin
            tv[0] <= (state == S_FETCH) && !abort;
            ti[0] <= fcnt;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                tv[i] <= tv[i-1];
                ti[i] <= ti[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            chunk      <= '0;
            fcnt       <= '0;
            calc       <= '0;
            stored     <= '0;
            syn_q      <= '0;
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            res_status <= '0;
            res_chunk  <= '0;
            res_byte   <= '0;
            res_bit    <= '0;
            cnt_corr   <= '0;
            cnt_eccerr <= '0;
            cnt_uncorr <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            ram_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cap_v) begin
                if (cap_i < 3'd3) calc[8*cap_i +: 8] <= ram_dout;
                else stored[8*(cap_i-3'd3) +: 8] <= ram_dout;
            end
            case (state)
                S_IDLE: if (start) begin
                    cnt_corr   <= '0;
                    cnt_eccerr <= '0;
                    cnt_uncorr <= '0;
                    chunk      <= '0;
                    fcnt       <= '0;
                    busy       <= 1'b1;
                    ram_en     <= 1'b1;
                    ram_addr   <= addr_of('0, 3'd0);
                    state      <= S_FETCH;
                end
                S_FETCH: if (fcnt == 3'd5) begin
                    ram_en <= 1'b0;
                    state  <= S_DRAIN;
                end else begin
                    fcnt     <= fcnt + 3'd1;
                    ram_addr <= addr_of(chunk, fcnt + 3'd1);
                end
                S_DRAIN: if (cap_v && cap_i == 3'd5) state <= S_SYND;
                S_SYND: begin
                    syn_q <= calc ^ stored;
                    state <= S_CLASS;
                end
                S_CLASS: begin
                    res_status <= cls_status;
                    res_chunk  <= chunk;
                    res_byte   <= (cls_status == CORRECTED) ? {chunk, cls_off} : '0;
                    res_bit    <= cls_bit;
                    cnt_corr   <= cnt_corr + (CW+1)'(cls_status == CORRECTED);
                    cnt_eccerr <= cnt_eccerr + (CW+1)'(cls_status == ECC_ERR);
                    cnt_uncorr <= cnt_uncorr + (CW+1)'(cls_status == UNCORR);
                    res_valid  <= 1'b1;
                    state      <= S_EMIT;
                end
                S_EMIT: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (chunk == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        chunk    <= chunk + 1'b1;
                        fcnt     <= '0;
                        ram_en   <= 1'b1;
                        ram_addr <= addr_of(chunk + 1'b1, 3'd0);
                        state    <= S_FETCH;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_ecc_checker.sv
// tb_read_ecc_checker: table-driven ECC injection with a result scoreboard,
// covering default parameters plus a 512-byte-chunk, 2-cycle-RAM variant.
module tb_read_ecc_checker;

    localparam int CLN = 0, COR = 1, EER = 2, UNC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1, abort, res_ready;

    logic        ram_en0, busy0, done0, res_valid0;
    logic [9:0]  ram_addr0;
    logic [7:0]  ram_dout0;
    logic [1:0]  res_status0;
    logic [5:0]  res_chunk0;
    logic [12:0] res_byte0;
    logic [2:0]  res_bit0;
    logic [6:0]  cnt_corr0, cnt_eccerr0, cnt_uncorr0;

    logic        ram_en1, busy1, done1, res_valid1;
    logic [9:0]  ram_addr1;
    logic [7:0]  ram_dout1, r1a;
    logic [1:0]  res_status1;
    logic [3:0]  res_chunk1;
    logic [12:0] res_byte1;
    logic [2:0]  res_bit1;
    logic [4:0]  cnt_corr1, cnt_eccerr1, cnt_uncorr1;

    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];

    always_ff @(posedge clk) if (ram_en0) ram_dout0 <= mem0[ram_addr0];
    always_ff @(posedge clk) begin
        if (ram_en1) r1a <= mem1[ram_addr1];
        ram_dout1 <= r1a;
    end

    read_ecc_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .ram_en(ram_en0), .ram_addr(ram_addr0), .ram_dout(ram_dout0),
        .busy(busy0), .done(done0), .res_valid(res_valid0), .res_ready(res_ready),
        .res_status(res_status0), .res_chunk(res_chunk0), .res_byte(res_byte0), .res_bit(res_bit0),
        .cnt_corr(cnt_corr0), .cnt_eccerr(cnt_eccerr0), .cnt_uncorr(cnt_uncorr0)
    );

    read_ecc_checker #(.CHUNK_LOG2(9), .NUM_CHUNKS(16), .RAM_RD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_dout(ram_dout1),
        .busy(busy1), .done(done1), .res_valid(res_valid1), .res_ready(res_ready),
        .res_status(res_status1), .res_chunk(res_chunk1), .res_byte(res_byte1), .res_bit(res_bit1),
        .cnt_corr(cnt_corr1), .cnt_eccerr(cnt_eccerr1), .cnt_uncorr(cnt_uncorr1)
    );

    typedef struct { int chunk; logic [23:0] flip; int st; int byte_a; int bit_a; } vec_t;
    typedef struct { int chunk; int st; int byte_a; int bit_a; } res_t;

    vec_t tab0 [10];
    vec_t tab1 [3];
    res_t exp0 [64];
    res_t exp1 [16];
    res_t sb [$];
    int   n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_res(input int chunk, input int st, input int by, input int bi);
        res_t e;
        if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("res_chunk", chunk, e.chunk);
        chk($sformatf("chunk%0d_status", e.chunk), st, e.st);
        chk($sformatf("chunk%0d_byte", e.chunk), by, e.byte_a);
        chk($sformatf("chunk%0d_bit", e.chunk), bi, e.bit_a);
    endtask

    task automatic load0(input bit inject);
        for (int c = 0; c < 64; c++) begin
            exp0[c] = '{c, CLN, 0, 0};
            for (int b = 0; b < 3; b++) begin
                mem0[1 + 3*c + b] = 8'($urandom);
                mem0[513 + 3*c + b] = mem0[1 + 3*c + b];
            end
        end
        for (int i = 0; i < 10 && inject; i++) begin
            logic [23:0] f;
            f = tab0[i].flip;
            for (int b = 0; b < 3; b++)
                mem0[513 + 3*tab0[i].chunk + b] = mem0[513 + 3*tab0[i].chunk + b] ^ f[8*b +: 8];
            exp0[tab0[i].chunk] = '{tab0[i].chunk, tab0[i].st, tab0[i].byte_a, tab0[i].bit_a};
        end
    endtask

    task automatic load1();
        for (int c = 0; c < 16; c++) begin
            exp1[c] = '{c, CLN, 0, 0};
            for (int b = 0; b < 3; b++) begin
                mem1[1 + 3*c + b] = 8'($urandom);
                mem1[513 + 3*c + b] = mem1[1 + 3*c + b];
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic [23:0] f;
            f = tab1[i].flip;
            for (int b = 0; b < 3; b++)
                mem1[513 + 3*tab1[i].chunk + b] = mem1[513 + 3*tab1[i].chunk + b] ^ f[8*b +: 8];
            exp1[tab1[i].chunk] = '{tab1[i].chunk, tab1[i].st, tab1[i].byte_a, tab1[i].bit_a};
        end
    endtask

    task automatic run0(input int stall_c, input int abort_c, input int poke_c, input int exp_cyc,
                        input int n_cor, input int n_eer, input int n_unc);
        int cyc;
        bit stalled, poked, aborted;
        stalled = 0; poked = 0; aborted = 0;
        sb.delete();
        for (int c = 0; c < 64; c++) sb.push_back(exp0[c]);
        start0 = 1;
        @(negedge clk);
        start0 = 0;
        cyc = 1;
        chk("busy_after_start", int'(busy0), 1);
        chk("cnt_corr_cleared", int'(cnt_corr0), 0);
        chk("cnt_eccerr_cleared", int'(cnt_eccerr0), 0);
        chk("cnt_uncorr_cleared", int'(cnt_uncorr0), 0);
        while (!done0 && !aborted && cyc < 2000) begin
            if (res_valid0 && int'(res_chunk0) == abort_c) begin
                abort = 1;
                @(negedge clk);
                abort = 0;
                aborted = 1;
                chk("abort_busy", int'(busy0), 0);
                chk("abort_valid", int'(res_valid0), 0);
                chk("abort_ram_en", int'(ram_en0), 0);
            end else begin
                if (res_valid0) begin
                    if (int'(res_chunk0) == stall_c && !stalled) begin
                        int bad;
                        bad = 0;
                        stalled = 1;
                        res_ready = 0;
                        repeat (20) begin
                            @(negedge clk);
                            cyc++;
                            if (!res_valid0 || ram_en0 || int'(res_chunk0) != sb[0].chunk ||
                                int'(res_status0) != sb[0].st || int'(res_byte0) != sb[0].byte_a ||
                                int'(res_bit0) != sb[0].bit_a) bad++;
                        end
                        chk("stall_hold_bad_cycles", bad, 0);
                        res_ready = 1;
                    end
                    if (int'(res_chunk0) == poke_c && !poked) begin
                        poked = 1;
                        start0 = 1;
                    end
                    cmp_res(int'(res_chunk0), int'(res_status0), int'(res_byte0), int'(res_bit0));
                end
                @(negedge clk);
                start0 = 0;
                cyc++;
            end
        end
        if (aborted) begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (done0 || busy0) seen++;
            end
            chk("no_done_after_abort", seen, 0);
        end else begin
            chk("done_seen", int'(done0), 1);
            chk("done_latency", (cyc >= exp_cyc - 2 && cyc <= exp_cyc + 2) ? exp_cyc : cyc, exp_cyc);
            chk("results_left", sb.size(), 0);
            @(negedge clk);
            chk("done_one_cycle", int'(done0), 0);
            chk("busy_after_done", int'(busy0), 0);
        end
        chk("cnt_corr", int'(cnt_corr0), n_cor);
        chk("cnt_eccerr", int'(cnt_eccerr0), n_eer);
        chk("cnt_uncorr", int'(cnt_uncorr0), n_unc);
    endtask

    task automatic run1();
        int cyc;
        sb.delete();
        for (int c = 0; c < 16; c++) sb.push_back(exp1[c]);
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        cyc = 1;
        while (!done1 && cyc < 1000) begin
            if (res_valid1) cmp_res(int'(res_chunk1), int'(res_status1), int'(res_byte1), int'(res_bit1));
            @(negedge clk);
            cyc++;
        end
        chk("k9_done_seen", int'(done1), 1);
        chk("k9_done_latency", (cyc >= 174 && cyc <= 178) ? 176 : cyc, 176);
        chk("k9_results_left", sb.size(), 0);
        chk("k9_cnt_corr", int'(cnt_corr1), 2);
        chk("k9_cnt_eccerr", int'(cnt_eccerr1), 0);
        chk("k9_cnt_uncorr", int'(cnt_uncorr1), 0);
    endtask

    initial begin
        tab0[0] = '{5,  24'h1A1999, COR, 682, 3};
        tab0[1] = '{0,  24'h000100, EER, 0, 0};
        tab0[2] = '{1,  24'h000003, UNC, 0, 0};
        tab0[3] = '{63, 24'h2AAAAA, COR, 8191, 7};
        tab0[4] = '{7,  24'h151555, COR, 896, 0};
        tab0[5] = '{8,  24'hC0C000, CLN, 0, 0};
        tab0[6] = '{9,  24'hC0C100, EER, 0, 0};
        tab0[7] = '{10, 24'h010000, EER, 0, 0};
        tab0[8] = '{11, 24'h1A1998, UNC, 0, 0};
        tab0[9] = '{12, 24'h262965, COR, 1636, 5};
        tab1[0] = '{15, 24'h2AAAAA, COR, 8191, 7};
        tab1[1] = '{3,  24'h155555, COR, 1536, 0};
        tab1[2] = '{4,  24'hC00000, CLN, 0, 0};

        rst = 0; start0 = 0; start1 = 0; abort = 0; res_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_valid", int'(res_valid0), 0);
        chk("rst_ram_en", int'(ram_en0), 0);
        chk("rst_ram_addr", int'(ram_addr0), 0);
        chk("rst_cnt_corr", int'(cnt_corr0), 0);
        chk("rst_busy_k9", int'(busy1), 0);
        rst = 1;
        @(negedge clk);

        load0(0);
        run0(-1, -1, -1, 640, 0, 0, 0);
        load0(1);
        run0(2, -1, -1, 660, 4, 3, 2);
        run0(-1, 10, 3, 0, 2, 3, 1);
        run0(-1, -1, -1, 640, 4, 3, 2);

        start0 = 1; abort = 1;
        @(negedge clk);
        start0 = 0; abort = 0;
        chk("start_abort_busy", int'(busy0), 0);
        chk("start_abort_ram_en", int'(ram_en0), 0);
        @(negedge clk);
        chk("start_abort_stays_idle", int'(busy0), 0);

        start0 = 1;
        @(negedge clk);
        start0 = 0;
        repeat (15) @(negedge clk);
        chk("midrun_ram_en", int'(ram_en0), 1);
        chk("midrun_status", int'(res_status0), EER);
        chk("midrun_cnt_eccerr", int'(cnt_eccerr0), 1);
        rst = 0;
        #1;
        chk("async_rst_busy", int'(busy0), 0);
        chk("async_rst_ram_en", int'(ram_en0), 0);
        chk("async_rst_status", int'(res_status0), 0);
        chk("async_rst_cnt_eccerr", int'(cnt_eccerr0), 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        load1();
        run1();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
